// File: rtl/case_conv_pkg.sv
// Shared types and constants for the UART case-converter sequencer.
package case_conv_pkg;

  localparam int unsigned BYTE_W = 8;

  // Sequencer states; one byte moves through all six per transfer.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    CAPTURE = 3'd2,
    WAIT_TX = 3'd3,
    PUSH    = 3'd4,
    SETTLE  = 3'd5
  } state_e;

  // Conversion mode encodings as seen on the mode input.
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam logic [BYTE_W-1:0] ASCII_A_UP = 8'h41;
  localparam logic [BYTE_W-1:0] ASCII_Z_UP = 8'h5A;
  localparam logic [BYTE_W-1:0] ASCII_A_LO = 8'h61;
  localparam logic [BYTE_W-1:0] ASCII_Z_LO = 8'h7A;
  localparam logic [BYTE_W-1:0] CASE_DELTA = 8'h20;

  function automatic logic is_upper(input logic [BYTE_W-1:0] c);
    return (c >= ASCII_A_UP) && (c <= ASCII_Z_UP);
  endfunction

  function automatic logic is_lower(input logic [BYTE_W-1:0] c);
    return (c >= ASCII_A_LO) && (c <= ASCII_Z_LO);
  endfunction

endpackage

// File: rtl/case_conv_ctrl_if.sv
// FIFO-side signal bundle of the case-converter sequencer.
// master = sequencer, slave = RX/TX FIFO pair.
interface case_conv_ctrl_if;
  import case_conv_pkg::*;

  logic              rx_empty;
  logic              rx_rd_en;
  logic [BYTE_W-1:0] rx_dout;
  logic              tx_full;
  logic              tx_wr_en;
  logic [BYTE_W-1:0] tx_din;

  modport master (
    input  rx_empty, rx_dout, tx_full,
    output rx_rd_en, tx_wr_en, tx_din
  );

  modport slave (
    output rx_empty, rx_dout, tx_full,
    input  rx_rd_en, tx_wr_en, tx_din
  );
endinterface

// File: rtl/case_conv_map.sv
// Purely combinational ASCII case mapping: (data, mode) -> converted byte.
// Codes outside A-Z / a-z always pass through unchanged.
module case_conv_map
  import case_conv_pkg::*;
(
  input  logic [BYTE_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  output logic [BYTE_W-1:0] data_o
);

  // Apply the upper/lower rules selected by mode.
  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_UPPER: begin
        if (is_lower(data_i)) data_o = data_i - CASE_DELTA;
      end
      MODE_LOWER: begin
        if (is_upper(data_i)) data_o = data_i + CASE_DELTA;
      end
      MODE_TOGGLE: begin
        if (is_lower(data_i))      data_o = data_i - CASE_DELTA;
        else if (is_upper(data_i)) data_o = data_i + CASE_DELTA;
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/case_conv_ctrl.sv
// RX FIFO -> case conversion -> TX FIFO sequencer.
// Optional statistics counters are enabled by defining CASE_CONV_STATS_EN.
module case_conv_ctrl
  import case_conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
`ifdef CASE_CONV_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  case_conv_ctrl_if.master  fifo,
  output logic              busy
`ifdef CASE_CONV_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic [CNT_WIDTH-1:0] conv_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] tx_din_q, tx_din_d;
  logic [DATA_WIDTH-1:0] conv;

  case_conv_map u_map (
    .data_i (data_q),
    .mode_i (mode_q),
    .data_o (conv)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mode_q   <= '0;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      tx_din_q <= tx_din_d;
    end
  end

  // Next-state and datapath loads. tx_din is registered while waiting for
  // TX space so that it already holds the converted byte during PUSH.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mode_d   = mode_q;
    tx_din_d = tx_din_q;
    case (state_q)
      IDLE:    if (enable && !fifo.rx_empty) state_d = POP;
      POP:     state_d = CAPTURE;
      CAPTURE: begin
        data_d  = fifo.rx_dout;
        mode_d  = mode;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        tx_din_d = conv;
        if (!fifo.tx_full) state_d = PUSH;
      end
      PUSH:    state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fifo.rx_rd_en = (state_q == POP);
  assign fifo.tx_wr_en = (state_q == PUSH);
  assign fifo.tx_din   = tx_din_q;
  assign busy          = (state_q != IDLE);

`ifdef CASE_CONV_STATS_EN
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH-1:0] conv_cnt_q, conv_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      conv_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      conv_cnt_q  <= conv_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Saturating increments; clear takes priority over any increment.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    conv_cnt_d  = conv_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      byte_cnt_d  = '0;
      conv_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (state_q == PUSH) begin
        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
        if ((tx_din_q != data_q) && (conv_cnt_q != '1))
          conv_cnt_d = conv_cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == WAIT_TX) && fifo.tx_full && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign byte_cnt  = byte_cnt_q;
  assign conv_cnt  = conv_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
